mem_bus_arbiter: RTL
====================

// Module: mem_bus_arbiter
// PURPOSE
//  Shares one external memory port between the IF-stage instruction fetch and the MEM-stage data access.
//  Sits between the core's IAD/IDT/ACKI_n and DAD/DDT/MREQ/WRITE/SIZE/ACKD_n buses and a single-port memory.
//  The core keeps its existing per-stage ACK interlocks; this block generates them.
//  Data accesses have priority; a starvation counter guarantees forward progress for fetch.
// PARAMETERS
//  STARVE_LIMIT  4  max consecutive data grants while a fetch is pending (legal range >=1)
// PORTS
//  clk      in   1   clock, all state on rising edge
//  rst      in   1   asynchronous, active-high reset
//  i_req    in   1   fetch request (IF stage; normally tied 1)
//  i_addr   in   32  fetch address (IAD)
//  i_rdata  out  32  fetched instruction (to IDT)
//  i_ack_n  out  1   fetch done, active-low, one-cycle pulse (to ACKI_n)
//  d_req    in   1   data request (MREQ)
//  d_write  in   1   1 = store (WRITE)
//  d_size   in   2   access size (SIZE encoding unchanged)
//  d_addr   in   32  data address (DAD)
//  d_wdata  in   32  store data
//  d_rdata  out  32  load data
//  d_ack_n  out  1   data done, active-low, one-cycle pulse (to ACKD_n)
//  m_req    out  1   memory request
//  m_write  out  1   memory write enable
//  m_size   out  2   memory access size
//  m_addr   out  32  memory address
//  m_wdata  out  32  memory write data
//  m_rdata  in   32  memory read data
//  m_ack_n  in   1   memory done, active-low
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE; m_req=0, m_write=0, m_size=0, m_addr=0, m_wdata=0;
//   i_ack_n=1, d_ack_n=1, i_rdata=0, d_rdata=0, starve_cnt=0.
//  FSM states: IDLE, I_GNT, D_GNT, I_ACK, D_ACK.
//  IDLE: arbitrate on registered decision.
//   d_req && !(i_req && starve_cnt==STARVE_LIMIT) -> D_GNT; else i_req -> I_GNT; else stay.
//   Grant latches addr/size/write/wdata into m_* regs. Fetch latches m_size=SIZE_WORD, m_write=0.
//  I_GNT/D_GNT: m_req=1, m_* held stable; requester inputs ignored (latched).
//   On m_ack_n==0: capture m_rdata into i_rdata/d_rdata, drop m_req and m_write -> I_ACK/D_ACK.
//  I_ACK/D_ACK: the matching ack_n=0 for exactly this cycle; m_req=0 -> IDLE.
//  Minimum access = 3 cycles (grant, mem ack, requester ack); no back-to-back without an IDLE cycle.
//  Rdata registers hold until the next completion of the same requester.
//  starve_cnt: +1 on each D grant taken while i_req=1 (saturates at STARVE_LIMIT);
//   cleared on every I grant; width $clog2(STARVE_LIMIT+1).
//  A request withdrawn before grant (flush) is never granted. A request withdrawn after grant
//   still completes and still pulses ack.
//  No timeout: a busy state waits on m_ack_n indefinitely.
//  Reset mid-transaction aborts it. No ack is issued. m_req drops immediately.
// STRUCTURE
//  Shared header mem_arb_defs.v: FSM state encodings (3-bit localparams), SIZE_WORD/HALF/BYTE codes
//   (same encoding as mem stage).
//  Single module; no sub-module needed (counter and FSM are small).
//  Top-level change: DDT tri-state stays in top; the arbiter uses split rdata/wdata.
// TESTING
//  Reset in D_GNT (m_req=1) asserts rst -> same cycle m_req=0, acks=1; after release, state IDLE, cnt=0.
//  Fetch only: i_addr=0x100, mem acks 2 cycles after m_req with 0x00000013 ->
//   m_size=SIZE_WORD, m_write=0; i_ack_n=0 one cycle; i_rdata=0x13.
//  Both request in IDLE, d_addr=0x8000, i_addr=0x104 -> m_addr=0x8000 first, d_ack_n pulse;
//   then m_addr=0x104, i_ack_n pulse.
//  Starvation, STARVE_LIMIT=4, d_req and i_req held high -> grant order D,D,D,D,I,D...; cnt returns to 0 after I.
//  Store: d_write=1, d_size=BYTE, d_addr=0x8003, d_wdata=0xAB -> m_write=1, m_wdata=0xAB held until m_ack_n=0;
//   one d_ack_n pulse; d_rdata unchanged.
//  d_req pulses high then low while I_GNT busy -> no D grant afterward; the next grant is I.

Source files
------------

// File: rtl/mem_bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mem_bus_arbiter_pkg
// Purpose : Shared encodings for the memory bus arbiter: FSM state codes,
//           access-size codes (same encoding as the MEM stage) and helpers.
// Rev     : 1.0  initial release
// ============================================================================
package mem_bus_arbiter_pkg;

  localparam int DATA_W = 32;

  typedef logic [2:0] state_t;
  typedef logic [1:0] size_t;

  // FSM state encodings
  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_I_GNT = 3'd1;
  localparam state_t ST_D_GNT = 3'd2;
  localparam state_t ST_I_ACK = 3'd3;
  localparam state_t ST_D_ACK = 3'd4;

  // Access size codes, identical to the MEM stage SIZE bus
  localparam size_t SIZE_BYTE = 2'b00;
  localparam size_t SIZE_HALF = 2'b01;
  localparam size_t SIZE_WORD = 2'b10;

  // True while the memory port is owned by a requester and awaiting m_ack_n
  function automatic logic is_grant(input state_t st);
    return (st == ST_I_GNT) || (st == ST_D_GNT);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : mem_bus_arbiter_if
// Purpose : Bundles the fetch, data and memory buses around the arbiter.
//           slave  = arbiter view, master = core/memory environment view.
// Rev     : 1.0  initial release
// ============================================================================
interface mem_bus_arbiter_if;
  import mem_bus_arbiter_pkg::*;

  // fetch side (IAD / IDT / ACKI_n)
  logic              i_req;
  logic [DATA_W-1:0] i_addr;
  logic [DATA_W-1:0] i_rdata;
  logic              i_ack_n;
  // data side (MREQ / WRITE / SIZE / DAD / DDT / ACKD_n)
  logic              d_req;
  logic              d_write;
  size_t             d_size;
  logic [DATA_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ack_n;
  // single-port memory side
  logic              m_req;
  logic              m_write;
  size_t             m_size;
  logic [DATA_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [DATA_W-1:0] m_rdata;
  logic              m_ack_n;

  modport slave (
    input  i_req, i_addr, d_req, d_write, d_size, d_addr, d_wdata, m_rdata, m_ack_n,
    output i_rdata, i_ack_n, d_rdata, d_ack_n, m_req, m_write, m_size, m_addr, m_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_write, d_size, d_addr, d_wdata, m_rdata, m_ack_n,
    input  i_rdata, i_ack_n, d_rdata, d_ack_n, m_req, m_write, m_size, m_addr, m_wdata
  );

endinterface
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : mem_bus_arbiter
// Purpose : Shares one memory port between instruction fetch and data access.
//           Data has priority; a starvation counter forces a fetch grant after
//           STARVE_LIMIT consecutive data grants taken while fetch was pending.
// Rev     : 1.0  initial release
// ============================================================================
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  mem_bus_arbiter_if.slave bus
);

  localparam int             CNT_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   starve_cnt_q, starve_cnt_d;
  logic               m_write_q;
  size_t              m_size_q;
  logic [DATA_W-1:0]  m_addr_q;
  logic [DATA_W-1:0]  m_wdata_q;
  logic [DATA_W-1:0]  i_rdata_q;
  logic [DATA_W-1:0]  d_rdata_q;

  logic               starved_w;
  logic               take_d_w;
  logic               take_i_w;

  // Fetch wins only when it is pending and data has used up its allowance
  assign starved_w = bus.i_req && (starve_cnt_q == CNT_MAX);
  assign take_d_w  = (state_q == ST_IDLE) && bus.d_req && !starved_w;
  assign take_i_w  = (state_q == ST_IDLE) && !take_d_w && bus.i_req;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (take_d_w) begin
          state_d = ST_D_GNT;
        end else if (take_i_w) begin
          state_d = ST_I_GNT;
        end
      end
      ST_I_GNT: if (!bus.m_ack_n) state_d = ST_I_ACK;
      ST_D_GNT: if (!bus.m_ack_n) state_d = ST_D_ACK;
      ST_I_ACK: state_d = ST_IDLE;
      ST_D_ACK: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from the current state
  always_comb begin
    bus.m_req   = is_grant(state_q);
    bus.i_ack_n = (state_q != ST_I_ACK);
    bus.d_ack_n = (state_q != ST_D_ACK);
  end

  // Starvation counter: counts data grants that overtook a pending fetch
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (take_i_w) begin
      starve_cnt_d = '0;
    end else if (take_d_w && bus.i_req && (starve_cnt_q != CNT_MAX)) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end
  end

  // Starvation counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

  // Request latch at grant and read-data capture at memory completion
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_write_q <= 1'b0;
      m_size_q  <= SIZE_BYTE;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      if (take_d_w) begin
        m_write_q <= bus.d_write;
        m_size_q  <= bus.d_size;
        m_addr_q  <= bus.d_addr;
        m_wdata_q <= bus.d_wdata;
      end else if (take_i_w) begin
        m_write_q <= 1'b0;
        m_size_q  <= SIZE_WORD;
        m_addr_q  <= bus.i_addr;
      end
      if (is_grant(state_q) && !bus.m_ack_n) begin
        m_write_q <= 1'b0;
        if (state_q == ST_I_GNT) begin
          i_rdata_q <= bus.m_rdata;
        end else if (!m_write_q) begin
          // stores leave the load-data register untouched
          d_rdata_q <= bus.m_rdata;
        end
      end
    end
  end

  assign bus.m_write = m_write_q;
  assign bus.m_size  = m_size_q;
  assign bus.m_addr  = m_addr_q;
  assign bus.m_wdata = m_wdata_q;
  assign bus.i_rdata = i_rdata_q;
  assign bus.d_rdata = d_rdata_q;

endmodule
`default_nettype wire
